// File: rtl/accel_job_dispatcher.sv
// Queued job front-end: a FIFO of (engine, config) jobs issued one at a time to
// NUM_ENGINES compute engines, with per-engine clock enables, watchdog and error flags.
module accel_job_dispatcher #(
   parameter int unsigned NUM_ENGINES    = 3,
   parameter int unsigned QUEUE_DEPTH    = 4,
   parameter int unsigned CFG_WIDTH      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned GATE_HOLD      = 16,
   localparam int unsigned EW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1,
   localparam int unsigned QW = $clog2(QUEUE_DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   job_valid,
   output logic                   job_ready,
   input  logic [EW-1:0]          job_engine,
   input  logic [CFG_WIDTH-1:0]   job_config,
   input  logic                   abort,
   input  logic                   clear_errors,
   output logic [NUM_ENGINES-1:0] eng_clk_en,
   output logic [NUM_ENGINES-1:0] eng_start,
   output logic [CFG_WIDTH-1:0]   eng_config,
   input  logic [NUM_ENGINES-1:0] eng_done,
   input  logic [NUM_ENGINES-1:0] eng_error,
   output logic                   busy,
   output logic                   done_pulse,
   output logic [2:0]             current_state,
   output logic [7:0]             error_flags,
   output logic [QW-1:0]          queue_count,
   output logic [15:0]            jobs_completed
);

   localparam int unsigned PW = $clog2(QUEUE_DEPTH);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
   localparam int unsigned HW = (GATE_HOLD > 0) ? $clog2(GATE_HOLD + 1) : 1;
   localparam int unsigned JW = EW + CFG_WIDTH;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAKE     = 3'd1,
      START    = 3'd2,
      RUN      = 3'd3,
      COMPLETE = 3'd4,
      ERROR    = 3'd5
   } state_t;

   state_t                 state, state_next;
   logic [JW-1:0]          fifo_mem [QUEUE_DEPTH];
   logic [PW-1:0]          wr_ptr, rd_ptr;
   logic [QW-1:0]          count_next;
   logic [EW-1:0]          active, active_next;
   logic [CFG_WIDTH-1:0]   cfg_next;
   logic [TW-1:0]          tcnt, tcnt_next;
   logic [HW-1:0]          hold      [NUM_ENGINES];
   logic [HW-1:0]          hold_next [NUM_ENGINES];
   logic [3:0]             flags, flags_set;
   logic                   push, pop, end_job;
   logic [EW-1:0]          head_engine;
   logic [CFG_WIDTH-1:0]   head_config;
   logic [NUM_ENGINES-1:0] active_onehot, start_next, en_next;

   assign push = job_valid & job_ready & ~abort;
   assign {head_engine, head_config} = fifo_mem[rd_ptr];
   assign current_state = state;
   assign error_flags   = {4'b0000, flags};

   always_comb begin
      for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
         active_onehot[i] = (active == EW'(i));
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state, dispatch and error detection
   always_comb begin
      state_next  = state;
      active_next = active;
      cfg_next    = eng_config;
      tcnt_next   = tcnt;
      pop         = 1'b0;
      flags_set   = '0;
      case (state)
         IDLE: begin
            if (queue_count != '0) begin
               pop = 1'b1;
               if ({1'b0, head_engine} >= (EW + 1)'(NUM_ENGINES)) begin
                  flags_set[0] = 1'b1;
               end else begin
                  active_next = head_engine;
                  cfg_next    = head_config;
                  state_next  = WAKE;
               end
            end
         end
         WAKE:  state_next = START;
         START: begin
            tcnt_next  = '0;
            state_next = RUN;
         end
         RUN: begin
            if (|(eng_done & active_onehot)) begin
               if (|(eng_error & active_onehot)) begin
                  flags_set[2] = 1'b1;
                  state_next   = ERROR;
               end else begin
                  state_next = COMPLETE;
               end
            end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
               flags_set[1] = 1'b1;
               state_next   = ERROR;
            end else begin
               tcnt_next = tcnt + TW'(1);
            end
         end
         COMPLETE: state_next = IDLE;
         ERROR:    state_next = IDLE;
         default:  state_next = IDLE;
      endcase
      // Done from a non-active engine, or outside RUN, is flagged and ignored
      flags_set[3] = (state == RUN) ? |(eng_done & ~active_onehot) : |eng_done;
      if (abort) begin
         state_next     = IDLE;
         active_next    = active;
         cfg_next       = eng_config;
         pop            = 1'b0;
         flags_set[2:0] = '0;
      end
   end

   always_comb begin
      count_next = queue_count;
      if (abort)              count_next = '0;
      else if (push && !pop)  count_next = queue_count + QW'(1);
      else if (pop && !push)  count_next = queue_count - QW'(1);
   end

   // Clock-enable hold: reloaded when the active engine's job ends (or is aborted)
   assign end_job = (state != IDLE) && (abort || state == COMPLETE || state == ERROR);

   always_comb begin
      for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
         hold_next[i] = (hold[i] != '0) ? hold[i] - HW'(1) : hold[i];
         if (GATE_HOLD != 0 && end_job && active_onehot[i]) hold_next[i] = HW'(GATE_HOLD);
         en_next[i]    = ((state_next != IDLE) && (active_next == EW'(i))) || (hold_next[i] != '0);
         start_next[i] = (state_next == START) && (active_next == EW'(i));
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < QUEUE_DEPTH; i++) fifo_mem[i] <= '0;
         for (int unsigned i = 0; i < NUM_ENGINES; i++) hold[i] <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         queue_count    <= '0;
         active         <= '0;
         tcnt           <= '0;
         flags          <= '0;
         job_ready      <= 1'b1;
         eng_clk_en     <= '0;
         eng_start      <= '0;
         eng_config     <= '0;
         busy           <= 1'b0;
         done_pulse     <= 1'b0;
         jobs_completed <= '0;
      end else begin
         if (push) fifo_mem[wr_ptr] <= {job_engine, job_config};
         if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
         end
         for (int unsigned i = 0; i < NUM_ENGINES; i++) hold[i] <= hold_next[i];
         queue_count <= count_next;
         active      <= active_next;
         tcnt        <= tcnt_next;
         flags       <= (clear_errors ? 4'b0000 : flags) | flags_set;
         job_ready   <= (count_next < QW'(QUEUE_DEPTH));
         eng_clk_en  <= en_next;
         eng_start   <= start_next;
         eng_config  <= cfg_next;
         busy        <= (state_next != IDLE) || (count_next != '0);
         done_pulse  <= (state_next == COMPLETE);
         if (state_next == COMPLETE) jobs_completed <= jobs_completed + 16'd1;
      end
   end

endmodule

// File: tb/tb_accel_job_dispatcher.sv
// Scoreboard bench for accel_job_dispatcher: accepted jobs are queued as expected
// starts and checked when the engine start pulse appears.
module tb_accel_job_dispatcher;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        job_valid, job_ready, abort, clear_errors;
   logic [1:0]  job_engine;
   logic [15:0] job_config;
   logic [2:0]  eng_clk_en, eng_start, eng_done, eng_error;
   logic [15:0] eng_config;
   logic        busy, done_pulse;
   logic [2:0]  current_state;
   logic [7:0]  error_flags;
   logic [2:0]  queue_count;
   logic [15:0] jobs_completed;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          done_cnt = 0;
   int          exp_jobs = 0;
   logic [17:0] sb [$];
   logic [17:0] sb_head;

   accel_job_dispatcher #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_engine(job_engine), .job_config(job_config),
      .abort(abort), .clear_errors(clear_errors),
      .eng_clk_en(eng_clk_en), .eng_start(eng_start), .eng_config(eng_config),
      .eng_done(eng_done), .eng_error(eng_error),
      .busy(busy), .done_pulse(done_pulse), .current_state(current_state),
      .error_flags(error_flags), .queue_count(queue_count),
      .jobs_completed(jobs_completed)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_job(input logic [1:0] eng, input logic [15:0] cfg);
      int n = 0;
      while (!job_ready && n < 60) begin tick(); n++; end
      if (!job_ready) check("push_ready", 32'(job_ready), 32'd1);
      job_valid  = 1'b1;
      job_engine = eng;
      job_config = cfg;
      if (eng < 2'd3) sb.push_back({eng, cfg});
      tick();
      job_valid = 1'b0;
   endtask

   task automatic wait_start(input int eng);
      int n = 0;
      while (eng_start[eng] !== 1'b1 && n < 60) begin tick(); n++; end
      check("start_seen", 32'(eng_start[eng]), 32'd1);
   endtask

   task automatic wait_state(input logic [2:0] s, input string tag);
      int n = 0;
      while (current_state !== s && n < 60) begin tick(); n++; end
      check(tag, 32'(current_state), 32'(s));
   endtask

   // Returns in the cycle after done is sampled
   task automatic serve(input int eng, input int dly, input logic err);
      wait_start(eng);
      repeat (dly) tick();
      eng_done[eng]  = 1'b1;
      eng_error[eng] = err;
      tick();
      eng_done  = '0;
      eng_error = '0;
   endtask

   // Start monitor: every start pulse must match the oldest accepted valid job
   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         if (done_pulse) done_cnt++;
         if (eng_start != '0) begin
            if (sb.size() == 0) begin
               check("start_unexpected", 32'(eng_start), 32'd0);
            end else begin
               sb_head = sb.pop_front();
               check("start_engine", 32'(eng_start), 32'd1 << sb_head[17:16]);
               check("start_config", 32'(eng_config), 32'(sb_head[15:0]));
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; job_valid = 1'b0; job_engine = '0; job_config = '0;
      abort = 1'b0; clear_errors = 1'b0; eng_done = '0; eng_error = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_ready", 32'(job_ready), 32'd1);
      check("rst_clk_en", 32'(eng_clk_en), 32'd0);
      check("rst_start", 32'(eng_start), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_state", 32'(current_state), 32'd0);
      check("rst_flags", 32'(error_flags), 32'd0);
      check("rst_count", 32'(queue_count), 32'd0);
      check("rst_jobs", 32'(jobs_completed), 32'd0);
      tick();

      // Single job: engine 1, config 0x1234, done 5 cycles after start
      push_job(2'd1, 16'h1234);
      check("t1_c1_count", 32'(queue_count), 32'd1);
      check("t1_c1_state", 32'(current_state), 32'd0);
      check("t1_c1_clk_en", 32'(eng_clk_en), 32'd0);
      tick();
      check("t1_c2_state", 32'(current_state), 32'd1);
      check("t1_c2_clk_en", 32'(eng_clk_en), 32'b010);
      check("t1_c2_start", 32'(eng_start), 32'd0);
      tick();
      check("t1_c3_state", 32'(current_state), 32'd2);
      check("t1_c3_start", 32'(eng_start), 32'b010);
      check("t1_c3_config", 32'(eng_config), 32'h1234);
      repeat (5) tick();
      eng_done = 3'b010;
      tick();
      eng_done = '0;
      exp_jobs++;
      check("t1_complete", 32'(current_state), 32'd4);
      check("t1_done_pulse", 32'(done_pulse), 32'd1);
      check("t1_jobs", 32'(jobs_completed), 32'(exp_jobs));
      tick();
      check("t1_done_once", 32'(done_pulse), 32'd0);
      check("t1_idle_busy", 32'(busy), 32'd0);
      repeat (15) tick();
      check("t1_hold_last", 32'(eng_clk_en), 32'b010);
      tick();
      check("t1_hold_drop", 32'(eng_clk_en), 32'd0);

      // Five jobs back-to-back with done withheld on the first
      push_job(2'd0, 16'h0A00);
      push_job(2'd1, 16'h0A01);
      push_job(2'd2, 16'h0A02);
      push_job(2'd0, 16'h0A03);
      push_job(2'd1, 16'h0A04);
      check("t2_full_count", 32'(queue_count), 32'd4);
      check("t2_full_ready", 32'(job_ready), 32'd0);
      check("t2_run", 32'(current_state), 32'd3);
      job_valid = 1'b1; job_engine = 2'd2; job_config = 16'hDEAD;
      tick(); tick();
      job_valid = 1'b0;
      check("t2_full_reject", 32'(queue_count), 32'd4);
      check("t2_full_noerr", 32'(error_flags), 32'd0);
      eng_done = 3'b001;
      tick();
      eng_done = '0;
      serve(1, 2, 1'b0);
      serve(2, 1, 1'b0);
      serve(0, 3, 1'b0);
      serve(1, 1, 1'b0);
      exp_jobs += 5;
      check("t2_jobs", 32'(jobs_completed), 32'(exp_jobs));
      check("t2_sb_empty", 32'(sb.size()), 32'd0);
      tick();
      check("t2_ready_back", 32'(job_ready), 32'd1);

      // Invalid engine ID is dropped; next job still runs
      push_job(2'd3, 16'h0BAD);
      push_job(2'd2, 16'h0042);
      serve(2, 1, 1'b0);
      exp_jobs++;
      check("t3_complete", 32'(current_state), 32'd4);
      check("t3_flags", 32'(error_flags), 32'h01);
      tick();
      clear_errors = 1'b1;
      tick();
      clear_errors = 1'b0;
      check("t3_cleared", 32'(error_flags), 32'd0);

      // Watchdog: no done for 8 RUN cycles
      push_job(2'd0, 16'h0777);
      wait_state(3'd3, "t4_reach_run");
      repeat (7) tick();
      check("t4_last_run", 32'(current_state), 32'd3);
      tick();
      check("t4_error", 32'(current_state), 32'd5);
      check("t4_flags", 32'(error_flags), 32'h02);
      check("t4_no_done", 32'(done_pulse), 32'd0);
      tick();
      check("t4_jobs", 32'(jobs_completed), 32'(exp_jobs));
      clear_errors = 1'b1;
      tick();
      clear_errors = 1'b0;
      check("t4_cleared", 32'(error_flags), 32'd0);

      // Done on the final watchdog cycle wins
      push_job(2'd1, 16'h0888);
      wait_state(3'd3, "t4b_reach_run");
      repeat (7) tick();
      eng_done = 3'b010;
      tick();
      eng_done = '0;
      exp_jobs++;
      check("t4b_complete", 32'(current_state), 32'd4);
      check("t4b_flags", 32'(error_flags), 32'd0);

      // Engine error, then a stray done during another run
      push_job(2'd1, 16'h0101);
      serve(1, 2, 1'b1);
      check("t5_error", 32'(current_state), 32'd5);
      check("t5_flags", 32'(error_flags), 32'h04);
      check("t5_no_done", 32'(done_pulse), 32'd0);
      clear_errors = 1'b1;
      tick();
      clear_errors = 1'b0;
      push_job(2'd2, 16'h0202);
      wait_start(2);
      tick();
      eng_done = 3'b001;
      tick();
      eng_done = '0;
      check("t5_stray_flag", 32'(error_flags), 32'h08);
      check("t5_still_run", 32'(current_state), 32'd3);
      tick();
      eng_done = 3'b100;
      tick();
      eng_done = '0;
      exp_jobs++;
      check("t5_complete", 32'(current_state), 32'd4);
      check("t5_jobs", 32'(jobs_completed), 32'(exp_jobs));
      clear_errors = 1'b1;
      tick();
      clear_errors = 1'b0;
      repeat (20) tick();

      // Abort during RUN with two jobs queued
      push_job(2'd0, 16'h0C00);
      push_job(2'd1, 16'h0C01);
      push_job(2'd2, 16'h0C02);
      wait_state(3'd3, "t6_reach_run");
      check("t6_queued", 32'(queue_count), 32'd2);
      abort = 1'b1;
      sb.delete();
      tick();
      abort = 1'b0;
      check("t6_idle", 32'(current_state), 32'd0);
      check("t6_count", 32'(queue_count), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_no_done", 32'(done_pulse), 32'd0);
      repeat (15) tick();
      check("t6_hold_last", 32'(eng_clk_en), 32'b001);
      tick();
      check("t6_hold_drop", 32'(eng_clk_en), 32'd0);
      check("t6_jobs", 32'(jobs_completed), 32'(exp_jobs));
      check("t6_done_count", 32'(done_cnt), 32'(exp_jobs));

      // Asynchronous reset mid-job
      push_job(2'd2, 16'h0D00);
      push_job(2'd0, 16'h0D01);
      wait_state(3'd3, "t7_reach_run");
      #2 rst_n = 1'b0;
      #1;
      check("t7_state", 32'(current_state), 32'd0);
      check("t7_clk_en", 32'(eng_clk_en), 32'd0);
      check("t7_count", 32'(queue_count), 32'd0);
      check("t7_ready", 32'(job_ready), 32'd1);
      check("t7_jobs", 32'(jobs_completed), 32'd0);
      sb.delete();
      tick();
      rst_n = 1'b1;
      repeat (5) tick();
      check("t7_stays_idle", 32'(current_state), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/accel_job_dispatcher.md
# accel_job_dispatcher

Parametrised job front-end for the accelerator fabric. It generalises the single-shot start/done control path to a queued, multi-engine dispatcher. Jobs (engine ID plus config word) enter a FIFO and are issued one at a time to NUM_ENGINES compute engines (MLP/CNN/RNN and later additions). Each engine gets its own clock enable, an engine-done timeout watchdog, sticky error flags and a completion counter.

## Interface
- NUM_ENGINES, 3: number of compute engines; engine ID width EW = max(1, $clog2(NUM_ENGINES)).
- QUEUE_DEPTH, 4: job FIFO depth; must be a power of 2 and at least 2.
- CFG_WIDTH, 16: width of the per-job config word.
- TIMEOUT_CYCLES, 4096: maximum number of RUN cycles before a timeout is declared; at least 2.
- GATE_HOLD, 16: cycles an engine clock enable stays high after its job ends; 0 means drop immediately.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- job_valid  in  1  job offer
- job_ready  out  1  FIFO can accept a job (count < QUEUE_DEPTH)
- job_engine  in  EW  target engine ID
- job_config  in  CFG_WIDTH  job config word
- abort  in  1  single-cycle pulse: cancel the current job and flush the queue
- clear_errors  in  1  single-cycle pulse: clear error_flags
- eng_clk_en  out  NUM_ENGINES  per-engine clock enable, registered
- eng_start  out  NUM_ENGINES  one-hot, one-cycle start pulse
- eng_config  out  CFG_WIDTH  config of the active job; held stable from START until the job ends
- eng_done  in  NUM_ENGINES  per-engine completion pulse
- eng_error  in  NUM_ENGINES  per-engine error; sampled only together with eng_done
- busy  out  1  state != IDLE, or queue not empty
- done_pulse  out  1  one cycle per successfully completed job
- current_state  out  3  FSM encoding
- error_flags  out  8  sticky error bits
- queue_count  out  $clog2(QUEUE_DEPTH)+1  FIFO occupancy
- jobs_completed  out  16  successful-job counter; wraps modulo 2^16

## Operation
- FSM states: IDLE=0, WAKE=1, START=2, RUN=3, COMPLETE=4, ERROR=5.
- IDLE: if queue_count > 0, pop the head job, latch the engine ID and config, and go to WAKE.
  - If the popped ID is >= NUM_ENGINES: set error_flags[0], drop the job, stay in IDLE, no start is issued.
- WAKE: one cycle. The active engine's clock enable is now high. Next state is START.
- START: eng_start[active] = 1 for exactly this cycle. Clear the timeout counter. Next state is RUN.
- RUN:
  - On eng_done[active]:
    - with eng_error[active] = 0: go to COMPLETE;
    - with eng_error[active] = 1: set error_flags[2] and go to ERROR.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 without a done: set error_flags[1] and go to ERROR.
  - Otherwise increment the timeout counter.
- COMPLETE: done_pulse = 1, jobs_completed += 1, go to IDLE.
- ERROR: one cycle; no done_pulse and no counter increment. Go to IDLE; remaining queued jobs keep dispatching.
- An eng_done[i] with i != active, or any eng_done while not in RUN: set error_flags[3] and ignore it.
- error_flags[7:4] are reserved and read 0.
- Clock gating: eng_clk_en[i] is high while i is the active engine in WAKE through COMPLETE/ERROR.
  - After the job ends, it stays high for GATE_HOLD more cycles via a per-engine hold counter.
  - A new job for the same engine reloads the hold; the job still passes through WAKE, so latency is uniform.
- abort: from any state, go to IDLE next cycle, empty the FIFO, no done_pulse. Hold counters continue so enables decay normally. abort has priority over a same-cycle push, pop or done.
- clear_errors: clears all flags. A flag set in the same cycle wins over the clear.

## Timing
- Reset values: all outputs 0 except job_ready = 1; FIFO empty, FSM in IDLE, hold counters 0.
- Push occurs when job_valid & job_ready. Push and pop in the same cycle are legal: count is unchanged and FIFO order is preserved.
- A full FIFO deasserts job_ready; a job_valid presented while full is not accepted and is not an error.
- Latency, with the queue empty and FSM in IDLE, job accepted in cycle 0:
  - cycle 1: pop, current_state = IDLE;
  - cycle 2: WAKE, eng_clk_en high;
  - cycle 3: START, eng_start high;
  - cycle 4 onward: RUN.
- eng_done seen in RUN cycle n: COMPLETE in cycle n+1 (done_pulse high), IDLE in n+2, next job popped at the end of n+2.
- Timeout: the watchdog expires on the TIMEOUT_CYCLES-th RUN cycle if eng_done has not been seen, and ERROR follows in the next cycle. An eng_done on that same final cycle wins.
- Asynchronous reset mid-job: everything returns to reset values immediately, including the FIFO contents.

## Test plan
- Single job, engine 1, config 0x1234, eng_done 5 cycles after start:
  - eng_clk_en = 3'b010 from cycle 2; eng_start[1] in cycle 3; eng_config = 0x1234;
  - done_pulse one cycle; jobs_completed = 1;
  - eng_clk_en drops exactly 16 cycles after COMPLETE.
- Push 5 jobs back-to-back with eng_done withheld (QUEUE_DEPTH = 4):
  - job_ready low once count = 4 while job 1 runs;
  - on release, all 5 jobs are issued in order with no loss.
- Job with engine ID 3 (NUM_ENGINES = 3): error_flags = 0x01, no eng_start, the next queued job still runs.
- No eng_done, TIMEOUT_CYCLES = 8: ERROR after 8 RUN cycles, error_flags[1] = 1, no done_pulse; clear_errors returns flags to 0.
- eng_done together with eng_error on the active engine → error_flags[2]; a stray eng_done[0] during engine 2's run → error_flags[3]; the run continues.
- abort during RUN with 2 jobs queued: IDLE next cycle, queue_count = 0, busy = 0, no done_pulse, enables decay after GATE_HOLD cycles.
